// File: rtl/generador_sensores.sv
// rtl/generador_sensores.sv - two-beam sensor stimulus generator for the parking barrier
module generador_sensores #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic [1:0]         sensor,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   n_entradas,
  output logic [CNT_W-1:0]   n_salidas
);

  typedef enum logic [1:0] {IDLE, FASE1, FASE2, FASE3} estado_t;

  estado_t            state;
  logic               dir_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] fase_cnt;

  // Sequence FSM: phase timing, registered beam pattern, status pulses and saturating counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      dwell_q    <= '0;
      fase_cnt   <= '0;
      sensor     <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      n_entradas <= '0;
      n_salidas  <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state == IDLE) begin
        // abort is meaningless here, so it never blocks a start
        if (start) begin
          state    <= FASE1;
          fase_cnt <= '0;
          dir_q    <= dir;
          dwell_q  <= (dwell == '0) ? DWELL_W'(1) : dwell;
          sensor   <= dir ? 2'b01 : 2'b10;
          busy     <= 1'b1;
        end
      end else if (abort) begin
        // abort wins over a coincident FASE3 completion: nothing is counted
        state    <= IDLE;
        fase_cnt <= '0;
        sensor   <= 2'b00;
        busy     <= 1'b0;
        aborted  <= 1'b1;
      end else if (fase_cnt == dwell_q - DWELL_W'(1)) begin
        fase_cnt <= '0;
        case (state)
          FASE1: begin
            state  <= FASE2;
            sensor <= 2'b11;
          end
          FASE2: begin
            state  <= FASE3;
            sensor <= dir_q ? 2'b10 : 2'b01;
          end
          default: begin
            state  <= IDLE;
            sensor <= 2'b00;
            busy   <= 1'b0;
            done   <= 1'b1;
            if (!dir_q) begin
              if (n_entradas != '1) n_entradas <= n_entradas + CNT_W'(1);
            end else begin
              if (n_salidas != '1) n_salidas <= n_salidas + CNT_W'(1);
            end
          end
        endcase
      end else begin
        fase_cnt <= fase_cnt + DWELL_W'(1);
      end
    end
  end

endmodule
